// File: rtl/bin_2_bcd_seq.sv
// Sequential shift-and-add-3 binary to BCD converter with valid/ready handshakes on both sides.
// Define BIN_2_BCD_SIGNED_EN to treat bin as two's complement and add the neg output.
module bin_2_bcd_seq #(
  parameter int W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [W-1:0]                  bin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [4*((W*3)/10+1)-1:0]     bcd,
  output logic                          busy
`ifdef BIN_2_BCD_SIGNED_EN
  ,
  output logic                          neg
`endif
);

  localparam int ND = (W*3)/10+1;
  localparam int CW = $clog2(W+1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      sr_q, sr_d;
  logic [4*ND-1:0]   dig_q, dig_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              out_valid_q, busy_q;
  logic [4*ND-1:0]   adj;
  logic [4*ND-1:0]   sh_dig;
  logic [W-1:0]      sh_sr;
  logic [W-1:0]      mag;
  logic              accept;
`ifdef BIN_2_BCD_SIGNED_EN
  logic              neg_q, neg_d;
`endif

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign bcd       = dig_q;
`ifdef BIN_2_BCD_SIGNED_EN
  assign neg       = neg_q;
  assign mag       = bin[W-1] ? ((~bin) + W'(1)) : bin;
`else
  assign mag       = bin;
`endif

  // The SHIFT state spends one extra cycle at cnt==W so out_valid lands W+1 edges after accept.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
`ifdef BIN_2_BCD_SIGNED_EN
    neg_d   = neg_q;
`endif
    adj = dig_q;
    for (int i = 0; i < ND; i++) begin
      if (dig_q[4*i +: 4] > 4'd4) begin
        adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
      end
    end
    {sh_dig, sh_sr} = {adj[4*ND-2:0], sr_q, 1'b0};

    case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          dig_d = sh_dig;
          sr_d  = sh_sr;
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (accept)         state_d = SHIFT;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      sr_d  = mag;
      dig_d = '0;
      cnt_d = '0;
`ifdef BIN_2_BCD_SIGNED_EN
      neg_d = bin[W-1];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      dig_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef BIN_2_BCD_SIGNED_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      dig_q       <= dig_d;
      cnt_q       <= cnt_d;
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
`ifdef BIN_2_BCD_SIGNED_EN
      neg_q       <= neg_d;
`endif
    end
  end

endmodule

// File: doc/bin_2_bcd_seq.md
BIN_2_BCD_SEQ -- requirements
Module: bin_2_bcd_seq

Interface
REQ-001 The block SHALL have parameter W, default 16, giving the binary input width; legal range 4..32.
REQ-002 The block SHALL derive localparam ND = (W*3)/10+1, the number of BCD digits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: bin holds a value to convert.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an input this cycle.
REQ-007 The block SHALL have port bin, input, W bits: the binary value, unsigned unless the REQ-024 macro is defined.
REQ-008 The block SHALL have port out_valid, output, 1 bit: bcd holds a finished result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have port bcd, output, 4*ND bits: packed BCD, digit 0 in bits [3:0].
REQ-011 The block SHALL have port busy, output, 1 bit: high in SHIFT and DONE.

Function
REQ-012 The FSM SHALL have exactly three states, IDLE, SHIFT and DONE, with IDLE as the reset state.
REQ-013 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready).
REQ-014 An input is accepted on a clock edge where in_valid && in_ready: bin is captured into a W-bit shift register, the 4*ND-bit digit register is cleared, the W-cycle bit counter is cleared, and the state becomes SHIFT.
REQ-015 Each SHIFT cycle SHALL first add 3 to every digit >4, then shift {digits, shift register} left by 1 and increment the counter.
REQ-016 After the W-th shift the state SHALL become DONE with out_valid=1; out_valid therefore rises exactly W+1 edges after the accepting edge.
REQ-017 bcd SHALL be driven from the digit register and stay stable while out_valid && !out_ready.
REQ-018 In DONE with out_ready=1: if in_valid=1, the new input SHALL be accepted (back-to-back, state becomes SHIFT); otherwise the state SHALL become IDLE. out_valid falls on the same edge in both cases.
REQ-019 The digit register SHALL keep its value until the next accept clears it; bcd is defined only while out_valid=1.
REQ-020 in_valid SHALL be ignored in SHIFT, and in DONE while out_ready=0; bin is sampled only on an accept edge.
REQ-021 For every input, every digit SHALL be 0..9, and the result SHALL equal the decimal value of the input for all values up to 2^W-1.

Reset
REQ-022 While rst=1, the block SHALL hold state=IDLE, in_ready=1, out_valid=0, busy=0, bcd=0, the counter at 0 and the shift register at 0, independent of clk.
REQ-023 Asserting rst mid-conversion SHALL abort the conversion with no out_valid pulse; the first edge after release behaves as IDLE.

Configuration
REQ-024 With macro BIN_2_BCD_SIGNED_EN defined, the block SHALL:
- treat bin as two's complement;
- add output port neg (1 bit, reset 0, valid with out_valid);
- on accept, capture |bin| into the shift register and the sign bit into neg.
-2^(W-1) SHALL convert to magnitude 2^(W-1) with neg=1.
Without the macro, the neg port and the negate logic SHALL be absent, and bin is unsigned.

Verification
REQ-025 With W=16, bin=0, out_ready=1: out_valid rises 17 edges after accept with bcd=20'h00000, then drops one cycle later.
REQ-026 With W=16, bin=65535, then bin=9999 presented back-to-back with in_valid and out_ready held high: bcd=20'h65535, then 20'h09999, in_ready pulses in DONE, and there is no IDLE gap.
REQ-027 With W=16, bin=1234 and out_ready held low 5 cycles after out_valid: bcd=20'h01234 stays stable and in_ready=0 throughout; out_ready=1 gives IDLE on the next edge.
REQ-028 With W=16, bin=500 and rst pulsed after 8 SHIFT cycles: all outputs go to their reset values immediately, and no out_valid appears within 30 cycles.
REQ-029 With BIN_2_BCD_SIGNED_EN, W=8: bin=8'h80 gives neg=1, bcd=12'h128; bin=8'h7F gives neg=0, bcd=12'h127; bin=8'hFF gives neg=1, bcd=12'h001.
REQ-030 With W=8, all 256 values checked against a decimal reference model with random in_valid/out_ready: every result matches and there are no lost or duplicated transfers.
